// File: rtl/fib_rr_sched_if.sv
// Client request/response and engine handshake bundle for fib_rr_sched.
// slave is the scheduler side; master is the surrounding environment.
interface fib_rr_sched_if #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 32
);
    logic [NUM_REQ-1:0]             req_vld;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_num;
    logic [NUM_REQ-1:0]             req_rdy;
    logic [NUM_REQ-1:0]             rsp_vld;
    logic [OUTPUT_WIDTH-1:0]        rsp_data;
    logic [NUM_REQ-1:0]             rsp_rdy;
    logic [INPUT_WIDTH-1:0]         eng_fib_in;
    logic                           eng_vld_in;
    logic                           eng_rdy_in;
    logic [OUTPUT_WIDTH-1:0]        eng_fib_out;
    logic                           eng_vld_out;
    logic                           eng_rdy_out;

    modport slave (
        input  req_vld,
        input  req_num,
        output req_rdy,
        output rsp_vld,
        output rsp_data,
        input  rsp_rdy,
        output eng_fib_in,
        output eng_vld_in,
        input  eng_rdy_in,
        input  eng_fib_out,
        input  eng_vld_out,
        output eng_rdy_out
    );

    modport master (
        output req_vld,
        output req_num,
        input  req_rdy,
        input  rsp_vld,
        input  rsp_data,
        output rsp_rdy,
        input  eng_fib_in,
        input  eng_vld_in,
        output eng_rdy_in,
        output eng_fib_out,
        output eng_vld_out,
        input  eng_rdy_out
    );
endinterface

// File: rtl/fib_rr_sched.sv
// Round-robin scheduler sharing one Fibonacci engine among NUM_REQ clients.
// One transaction at a time: grant, issue, wait for result, respond.
module fib_rr_sched #(
    parameter int  NUM_REQ      = 4,
    parameter int  INPUT_WIDTH  = 8,
    parameter int  OUTPUT_WIDTH = 32,
    localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic           clk,
    input  logic           rst,
    fib_rr_sched_if.slave  bus,
    output logic           busy,
    output logic [IDW-1:0] grant_id
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_REQ - 1);

    logic [1:0]              state_q, state_d;
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [IDW-1:0]          owner_q, owner_d;
    logic [INPUT_WIDTH-1:0]  num_q, num_d;
    logic [OUTPUT_WIDTH-1:0] res_q, res_d;

    logic                    win_found;
    logic [IDW-1:0]          win_idx;
    logic [INPUT_WIDTH-1:0]  win_num;
    int                      cand;
    logic [IDW-1:0]          cand_idx;

    logic [NUM_REQ-1:0]      req_rdy;
    logic [NUM_REQ-1:0]      rsp_vld;
    logic                    eng_vld_in;
    logic                    eng_rdy_out;

    // Rotating priority: the search starts just after the last grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr_q) + k) % NUM_REQ;
            cand_idx = IDW'(cand);
            if (!win_found && bus.req_vld[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_num = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDW'(i)) begin
                win_num = bus.req_num[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        num_d       = num_q;
        res_d       = res_q;
        req_rdy     = '0;
        rsp_vld     = '0;
        eng_vld_in  = 1'b0;
        eng_rdy_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                // No grant while reset is held: the edge would discard it.
                if (win_found && !rst) begin
                    req_rdy[win_idx] = 1'b1;
                    num_d            = win_num;
                    owner_d          = win_idx;
                    ptr_d            = win_idx;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_vld_in = 1'b1;
                if (bus.eng_rdy_in) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                eng_rdy_out = 1'b1;
                if (bus.eng_vld_out) begin
                    res_d   = bus.eng_fib_out;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_vld[owner_q] = 1'b1;
                if (bus.rsp_rdy[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_RST;
            owner_q <= '0;
            num_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            num_q   <= num_d;
            res_q   <= res_d;
        end
    end

    assign bus.req_rdy     = req_rdy;
    assign bus.rsp_vld     = rsp_vld;
    assign bus.rsp_data    = res_q;
    assign bus.eng_fib_in  = num_q;
    assign bus.eng_vld_in  = eng_vld_in;
    assign bus.eng_rdy_out = eng_rdy_out;
    assign busy            = (state_q != S_IDLE);
    assign grant_id        = owner_q;

endmodule

// File: tb/tb_fib_rr_sched.sv
// Bench for fib_rr_sched: behavioural engine plus directed and random
// scenarios checked against a round-robin/latency reference model.
module tb_fib_rr_sched;
    localparam int NR = 4;
    localparam int IW = 8;
    localparam int OW = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [1:0] grant_id;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;
    int m_ptr       = NR - 1;

    fib_rr_sched_if #(.NUM_REQ(NR), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

    fib_rr_sched #(
        .NUM_REQ(NR),
        .INPUT_WIDTH(IW),
        .OUTPUT_WIDTH(OW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fib(input int n);
        logic [31:0] a, b, t;
        a = 32'd0;
        b = 32'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int lat(input int n);
        return (n <= 1) ? 1 : n + 1;
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // Engine stand-in: one calculation at a time, latency per n.
    logic          eng_busy = 1'b0;
    logic [IW-1:0] eng_n    = '0;
    int            eng_done = 0;

    always @(posedge clk) begin
        if (rst) begin
            eng_busy <= 1'b0;
        end else if (!eng_busy && bus.eng_vld_in) begin
            eng_busy <= 1'b1;
            eng_n    <= bus.eng_fib_in;
            eng_done <= cyc + lat(int'(bus.eng_fib_in));
        end else if (eng_busy && bus.eng_vld_out && bus.eng_rdy_out) begin
            eng_busy <= 1'b0;
        end
    end

    assign bus.eng_rdy_in  = !eng_busy;
    assign bus.eng_vld_out = eng_busy && (cyc >= eng_done);
    assign bus.eng_fib_out = eng_busy ? fib(int'(eng_n)) : 32'hdead_beef;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        bus.req_vld = '0;
        bus.req_num = '0;
        bus.rsp_rdy = '0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        m_ptr = NR - 1;
    endtask

    task automatic wait_rsp(output bit to);
        to = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.rsp_vld != 0) begin
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic ack(input int id);
        tick();
        bus.rsp_rdy[id] = 1'b1;
        tick();
        bus.rsp_rdy[id] = 1'b0;
        @(negedge clk);
    endtask

    task automatic txn(input int id, input int n, input int hold,
                       output logic [3:0] rs, output int l,
                       output logic [31:0] d, output logic [3:0] vs,
                       output logic [1:0] gid, output bit to);
        int t0;
        l   = -1;
        d   = 'x;
        vs  = 'x;
        gid = 'x;
        tick();
        bus.req_vld[id]         = 1'b1;
        bus.req_num[id*IW +: IW] = IW'(n);
        @(negedge clk);
        rs = bus.req_rdy;
        t0 = cyc;
        tick();
        bus.req_vld[id] = 1'b0;
        wait_rsp(to);
        if (!to) begin
            l   = cyc - t0;
            d   = bus.rsp_data;
            vs  = bus.rsp_vld;
            gid = grant_id;
            repeat (hold) tick();
            ack(id);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.req_vld = '0;
        bus.req_num = '0;
        bus.rsp_rdy = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.req_rdy !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_req_rdy: got %b expected 0000", bus.req_rdy);
        end
        vectors++;
        if (bus.rsp_vld !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_rsp_vld: got %b expected 0000", bus.rsp_vld);
        end
        vectors++;
        if (bus.rsp_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_rsp_data: got %0h expected 0", bus.rsp_data);
        end
        vectors++;
        if (bus.eng_vld_in !== 1'b0 || bus.eng_rdy_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_eng_hs: got vld_in %b rdy_out %b expected 0 0",
                     bus.eng_vld_in, bus.eng_rdy_out);
        end
        vectors++;
        if (bus.eng_fib_in !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_eng_fib_in: got %0d expected 0", bus.eng_fib_in);
        end
        vectors++;
        if (busy !== 1'b0 || grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_status: got busy %b grant_id %0d expected 0 0",
                     busy, grant_id);
        end
        bus.req_vld = 4'b0001;
        #1;
        vectors++;
        if (bus.req_rdy !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_no_grant: got %b expected 0000", bus.req_rdy);
        end
        bus.req_vld = '0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_ptr = NR - 1;
    endtask

    task automatic test_single();
        logic [3:0]  rs, vs;
        logic [31:0] d;
        logic [1:0]  gid;
        int          l;
        bit          to;
        apply_reset();
        txn(0, 10, 0, rs, l, d, vs, gid, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL single_timeout: got no response expected response");
        end
        vectors++;
        if (rs !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_req_rdy: got %b expected 0001", rs);
        end
        vectors++;
        if (l != 13) begin
            miscompares++;
            $display("FAIL single_latency: got %0d expected 13", l);
        end
        vectors++;
        if (d !== 32'd55 || vs !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_rsp: got data %0d vld %b expected 55 0001", d, vs);
        end
        vectors++;
        if (gid !== 2'd0) begin
            miscompares++;
            $display("FAIL single_grant_id: got %0d expected 0", gid);
        end
    endtask

    task automatic test_edge();
        int          ns[3] = '{0, 1, 2};
        int          ed[3] = '{0, 1, 1};
        int          el[3] = '{3, 3, 5};
        logic [3:0]  rs, vs;
        logic [31:0] d;
        logic [1:0]  gid;
        int          l;
        bit          to;
        for (int k = 0; k < 3; k++) begin
            txn(2, ns[k], 0, rs, l, d, vs, gid, to);
            vectors++;
            if (to || rs !== 4'b0100 || vs !== 4'b0100) begin
                miscompares++;
                $display("FAIL edge_hs n=%0d: got to %0d rdy %b vld %b expected 0 0100 0100",
                         ns[k], to, rs, vs);
            end
            vectors++;
            if (d !== 32'(ed[k]) || l != el[k]) begin
                miscompares++;
                $display("FAIL edge_rsp n=%0d: got data %0d lat %0d expected %0d %0d",
                         ns[k], d, l, ed[k], el[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int          ns[2] = '{47, 48};
        logic [31:0] ed[2] = '{32'd2971215073, 32'd512559680};
        logic [3:0]  rs, vs;
        logic [31:0] d;
        logic [1:0]  gid;
        int          l;
        bit          to;
        for (int k = 0; k < 2; k++) begin
            txn(1, ns[k], 0, rs, l, d, vs, gid, to);
            vectors++;
            if (to || d !== ed[k]) begin
                miscompares++;
                $display("FAIL wrap_data n=%0d: got %0d expected %0d", ns[k], d, ed[k]);
            end
            vectors++;
            if (l != ns[k] + 3 || gid !== 2'd1) begin
                miscompares++;
                $display("FAIL wrap_timing n=%0d: got lat %0d gid %0d expected %0d 1",
                         ns[k], l, gid, ns[k] + 3);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        apply_reset();
        tick();
        bus.req_vld[3]      = 1'b1;
        bus.req_num[31:24] = 8'd5;
        @(negedge clk);
        vectors++;
        if (bus.req_rdy !== 4'b1000) begin
            miscompares++;
            $display("FAIL bp_grant: got %b expected 1000", bus.req_rdy);
        end
        tick();
        bus.req_vld[3] = 1'b0;
        wait_rsp(to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL bp_timeout: got no response expected response");
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            bus.req_vld[0]   = 1'b1;
            bus.req_num[7:0] = 8'd7;
            bus.rsp_rdy      = 4'b0111;
            @(negedge clk);
            vectors++;
            if (bus.rsp_vld !== 4'b1000 || bus.rsp_data !== 32'd5) begin
                miscompares++;
                $display("FAIL bp_hold c=%0d: got vld %b data %0d expected 1000 5",
                         c, bus.rsp_vld, bus.rsp_data);
            end
            vectors++;
            if (busy !== 1'b1 || bus.req_rdy !== 4'b0) begin
                miscompares++;
                $display("FAIL bp_busy c=%0d: got busy %b rdy %b expected 1 0000",
                         c, busy, bus.req_rdy);
            end
        end
        tick();
        bus.rsp_rdy = 4'b1000;
        @(negedge clk);
        vectors++;
        if (bus.rsp_vld !== 4'b1000) begin
            miscompares++;
            $display("FAIL bp_release: got %b expected 1000", bus.rsp_vld);
        end
        tick();
        bus.rsp_rdy = '0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || bus.rsp_vld !== 4'b0 || bus.req_rdy !== 4'b0001) begin
            miscompares++;
            $display("FAIL bp_idle: got busy %b vld %b rdy %b expected 0 0000 0001",
                     busy, bus.rsp_vld, bus.req_rdy);
        end
        tick();
        bus.req_vld[0] = 1'b0;
        wait_rsp(to);
        vectors++;
        if (to || bus.rsp_vld !== 4'b0001 || bus.rsp_data !== 32'd13) begin
            miscompares++;
            $display("FAIL bp_queued: got vld %b data %0d expected 0001 13",
                     bus.rsp_vld, bus.rsp_data);
        end
        if (!to) ack(0);
    endtask

    task automatic test_fair();
        int ns[4] = '{5, 3, 8, 2};
        int order[$];
        int owner;
        int resp;
        int w;
        owner = -1;
        resp  = 0;
        apply_reset();
        tick();
        for (int i = 0; i < NR; i++) bus.req_num[i*IW +: IW] = IW'(ns[i]);
        bus.req_vld = 4'hf;
        bus.rsp_rdy = 4'hf;
        for (int c = 0; c < 400 && resp < 5; c++) begin
            @(negedge clk);
            vectors++;
            if ($countones(bus.req_rdy) > 1 || $countones(bus.rsp_vld) > 1) begin
                miscompares++;
                $display("FAIL fair_onehot: got rdy %b vld %b expected at most one bit",
                         bus.req_rdy, bus.rsp_vld);
            end
            if (bus.req_rdy != 0) begin
                w = rr_pick(bus.req_vld, m_ptr);
                vectors++;
                if (bus.req_rdy !== 4'(1 << w)) begin
                    miscompares++;
                    $display("FAIL fair_grant: got %b expected %b", bus.req_rdy, 4'(1 << w));
                end
                m_ptr = w;
                owner = w;
                order.push_back(w);
            end
            if (bus.rsp_vld != 0) begin
                vectors++;
                if (bus.rsp_vld !== 4'(1 << owner) || bus.rsp_data !== fib(ns[owner])) begin
                    miscompares++;
                    $display("FAIL fair_rsp: got vld %b data %0d expected %b %0d",
                             bus.rsp_vld, bus.rsp_data, 4'(1 << owner), fib(ns[owner]));
                end
                resp++;
            end
            tick();
        end
        bus.req_vld = '0;
        bus.rsp_rdy = '0;
        vectors++;
        if (resp != 5) begin
            miscompares++;
            $display("FAIL fair_count: got %0d responses expected 5", resp);
        end
        for (int g = 0; g < 5; g++) begin
            vectors++;
            if (g >= order.size() || order[g] != g % NR) begin
                miscompares++;
                $display("FAIL fair_order g=%0d: got %0d expected %0d",
                         g, (g < order.size()) ? order[g] : -1, g % NR);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        apply_reset();
        tick();
        bus.req_vld[3]      = 1'b1;
        bus.req_num[31:24] = 8'd20;
        @(negedge clk);
        vectors++;
        if (bus.req_rdy !== 4'b1000) begin
            miscompares++;
            $display("FAIL rmid_grant: got %b expected 1000", bus.req_rdy);
        end
        tick();
        bus.req_vld[3] = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || bus.eng_rdy_out !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_wait: got busy %b rdy_out %b expected 1 1",
                     busy, bus.eng_rdy_out);
        end
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        vectors++;
        if (bus.req_rdy !== 4'b0 || bus.rsp_vld !== 4'b0 || bus.rsp_data !== 32'd0) begin
            miscompares++;
            $display("FAIL rmid_client: got rdy %b vld %b data %0d expected 0000 0000 0",
                     bus.req_rdy, bus.rsp_vld, bus.rsp_data);
        end
        vectors++;
        if (bus.eng_vld_in !== 1'b0 || bus.eng_rdy_out !== 1'b0 || bus.eng_fib_in !== 8'd0) begin
            miscompares++;
            $display("FAIL rmid_engine: got vld_in %b rdy_out %b fib_in %0d expected 0 0 0",
                     bus.eng_vld_in, bus.eng_rdy_out, bus.eng_fib_in);
        end
        vectors++;
        if (busy !== 1'b0 || grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL rmid_status: got busy %b gid %0d expected 0 0", busy, grant_id);
        end
        tick();
        rst   = 1'b0;
        m_ptr = NR - 1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.rsp_vld !== 4'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rmid_quiet c=%0d: got vld %b busy %b expected 0000 0",
                         c, bus.rsp_vld, busy);
            end
            tick();
        end
        bus.req_num[7:0]   = 8'd4;
        bus.req_num[31:24] = 8'd6;
        bus.req_vld        = 4'b1001;
        @(negedge clk);
        vectors++;
        if (bus.req_rdy !== 4'b0001) begin
            miscompares++;
            $display("FAIL rmid_first: got %b expected 0001", bus.req_rdy);
        end
        tick();
        bus.req_vld[0] = 1'b0;
        wait_rsp(to);
        vectors++;
        if (to || bus.rsp_vld !== 4'b0001 || bus.rsp_data !== 32'd3) begin
            miscompares++;
            $display("FAIL rmid_rsp0: got vld %b data %0d expected 0001 3",
                     bus.rsp_vld, bus.rsp_data);
        end
        if (!to) ack(0);
        vectors++;
        if (bus.req_rdy !== 4'b1000) begin
            miscompares++;
            $display("FAIL rmid_second: got %b expected 1000", bus.req_rdy);
        end
        tick();
        bus.req_vld[3] = 1'b0;
        wait_rsp(to);
        vectors++;
        if (to || bus.rsp_vld !== 4'b1000 || bus.rsp_data !== 32'd8) begin
            miscompares++;
            $display("FAIL rmid_rsp3: got vld %b data %0d expected 1000 8",
                     bus.rsp_vld, bus.rsp_data);
        end
        if (!to) ack(3);
    endtask

    task automatic test_random();
        bit         pend;
        bit         exp_busy;
        int         p_owner, p_n, p_due, w;
        logic [3:0] gnt_prev, exp_rdy, exp_rsp;
        pend     = 1'b0;
        p_owner  = 0;
        p_n      = 0;
        p_due    = 0;
        w        = 0;
        gnt_prev = '0;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                if (gnt_prev[i]) begin
                    bus.req_vld[i] = 1'b0;
                end else if (bus.req_vld[i]) begin
                    if ($urandom_range(0, 7) == 0) bus.req_vld[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.req_num[i*IW +: IW] = IW'($urandom_range(0, 20));
                    bus.req_vld[i]          = 1'b1;
                end
            end
            bus.rsp_rdy = 4'($urandom_range(0, 15));
            @(negedge clk);
            exp_busy = pend;
            exp_rdy  = '0;
            if (!pend && bus.req_vld != 0) begin
                w       = rr_pick(bus.req_vld, m_ptr);
                exp_rdy = 4'(1 << w);
            end
            exp_rsp = (pend && cyc >= p_due) ? 4'(1 << p_owner) : 4'b0;
            vectors++;
            if (bus.req_rdy !== exp_rdy) begin
                miscompares++;
                $display("FAIL rand_req_rdy cyc=%0d: got %b expected %b", cyc, bus.req_rdy, exp_rdy);
            end
            vectors++;
            if (bus.rsp_vld !== exp_rsp) begin
                miscompares++;
                $display("FAIL rand_rsp_vld cyc=%0d: got %b expected %b", cyc, bus.rsp_vld, exp_rsp);
            end
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL rand_busy cyc=%0d: got %b expected %b", cyc, busy, exp_busy);
            end
            if (pend) begin
                vectors++;
                if (grant_id !== 2'(p_owner)) begin
                    miscompares++;
                    $display("FAIL rand_grant_id cyc=%0d: got %0d expected %0d", cyc, grant_id, p_owner);
                end
            end
            if (exp_rsp != 0) begin
                vectors++;
                if (bus.rsp_data !== fib(p_n)) begin
                    miscompares++;
                    $display("FAIL rand_data cyc=%0d n=%0d: got %0d expected %0d",
                             cyc, p_n, bus.rsp_data, fib(p_n));
                end
            end
            gnt_prev = bus.req_rdy;
            if (exp_rdy != 0) begin
                pend    = 1'b1;
                p_owner = w;
                p_n     = int'(bus.req_num[w*IW +: IW]);
                p_due   = cyc + 2 + lat(p_n);
                m_ptr   = w;
            end else if (pend && cyc >= p_due && bus.rsp_rdy[p_owner]) begin
                pend = 1'b0;
            end
        end
        bus.req_vld = '0;
        bus.rsp_rdy = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_vld = '0;
        bus.req_num = '0;
        bus.rsp_rdy = '0;
        test_reset();
        test_single();
        test_edge();
        test_wrap();
        test_backpressure();
        test_fair();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
